skew_feed_sequencer: RTL and testbench
======================================

Name: skew_feed_sequencer

Overview:
Parametrised successor to the fixed 4x4 BRAM-to-array feed path. It sequences BRAM row reads, absorbs the 1-cycle BRAM read latency, and diagonally skews each row into per-lane streams for a systolic tile. The block serves CHANNELS parallel BRAM streams that share one address. It sits between the Mat_* BRAMs and the systolic_module tiles, replacing the free-running address counter and the Data_decoder pair. It adds runtime row count, start/busy/done handshake and zero-flush.

Parameters:
MATRIX_SIZE, 4, lanes per channel (array edge length); lane i is delayed by i cycles.
REG_WIDTH, 16, bits per lane element.
ADDR_WIDTH, 2, BRAM address width; max rows = 2**ADDR_WIDTH.
CHANNELS, 2, parallel BRAM streams sharing address and control.

Ports:
clk  in  1  single clock, all logic on posedge.
reset  in  1  synchronous, active-high.
start  in  1  pulse; accepted only in IDLE.
rows_m1  in  ADDR_WIDTH  number of rows minus 1; sampled when start is accepted.
bram_en  out  1  BRAM read enable.
bram_addr  out  ADDR_WIDTH  BRAM read address.
bram_rdata  in  CHANNELS*MATRIX_SIZE*REG_WIDTH  BRAM data, valid 1 cycle after bram_en.
lane_data  out  CHANNELS*MATRIX_SIZE*REG_WIDTH  skewed lane outputs.
lane_valid  out  MATRIX_SIZE  per-lane valid, shared by all channels.
compute_start  out  1  1-cycle pulse when the first lane-0 element appears.
busy  out  1  high from FETCH through DONE.
done  out  1  1-cycle pulse after the last lane element.

Behaviour:
- Reset values: bram_en=0, bram_addr=0, lane_data=0, lane_valid=0, compute_start=0, busy=0, done=0, state=IDLE. All skew registers are cleared.
- Reset mid-operation: everything returns to the reset values at the next edge. In-flight data is discarded and no done pulse is issued.
- Lane slicing: element (c,i) = bram_rdata[(c*MATRIX_SIZE+i)*REG_WIDTH +: REG_WIDTH]. Output uses the same slicing. Lane 0 is the least-significant lane.
- FSM states and transitions:
  - IDLE: start=1 latches rows_m1 -> FETCH.
  - FETCH: registered bram_en=1, bram_addr = 0, 1, ... rows_m1 (rows_m1+1 cycles) -> DRAIN.
  - DRAIN: bram_en=0; lasts exactly MATRIX_SIZE+1 cycles -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Timing, with start accepted at edge T:
  - Address r is presented at cycle T+1+r.
  - bram_rdata for row r arrives at T+2+r.
  - Lane i of row r is output at T+3+r+i. This is one capture register plus i skew stages.
  - compute_start pulses at T+3.
  - lane_valid[i] is high for cycles T+3+i through T+3+rows_m1+i.
  - done pulses at T+3+rows_m1+MATRIX_SIZE.
  - busy is high from T+1 through the done cycle inclusive.
- Zero-flush: when lane_valid[i]=0, lane i of every channel outputs 0. The tile therefore sees zeros before and after the skewed diagonal.
- bram_rdata is captured only on cycles following bram_en=1. Data on other cycles is ignored.
- start while busy, including the DONE cycle, is ignored. A new start is accepted the cycle after DONE, in IDLE.
- Back-to-back operations: the earliest new bram_en is 2 cycles after done.
- bram_addr holds its last value after FETCH. Address wrap is impossible because the counter stops at rows_m1.
- No arithmetic is performed; data passes through bit-exact.

Test Plan:
1. MATRIX_SIZE=4, CHANNELS=2, rows_m1=3; rows hold element value = 16*row + 4*chan + lane; start at cycle 0 -> compute_start@3; lane0 valid 3..6; lane3 valid 6..9 carrying 3,19,35,51 (chan0); done@10; busy 1..10.
2. rows_m1=0, single row 0x0004_0003_0002_0001 -> lane i = i+1 at cycle 3+i only; all other lane samples 0; done@7.
3. start pulsed at cycles 4 and 10 during the run of test 1 -> both ignored; exactly one done@10; start@11 accepted, bram_en@12.
4. reset asserted at cycle 5 of test 1 -> from cycle 6 all outputs 0, state IDLE, no done; a subsequent start behaves as test 1.
5. rows_m1=3 (full depth, ADDR_WIDTH=2) -> bram_addr sequence 0,1,2,3 then held at 3; bram_en high exactly 4 cycles.
6. Channel isolation: chan1 data all 0xFFFF, chan0 all 0 -> chan1 lanes show 0xFFFF only while valid; chan0 lanes stay 0.

Source files
------------

// File: rtl/skew_feed_sequencer.sv
// skew_feed_sequencer
// Sequences BRAM row reads for CHANNELS parallel streams sharing one address,
// absorbs the one-cycle BRAM read latency, and diagonally skews every row so
// lane i of each channel reaches the systolic tile i cycles after lane 0.
// Lanes outside their valid window are forced to zero (zero-flush).
module skew_feed_sequencer #(
    parameter int MATRIX_SIZE = 4,
    parameter int REG_WIDTH   = 16,
    parameter int ADDR_WIDTH  = 2,
    parameter int CHANNELS    = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic [ADDR_WIDTH-1:0]                     rows_m1,
    output logic                                      bram_en,
    output logic [ADDR_WIDTH-1:0]                     bram_addr,
    input  logic [CHANNELS*MATRIX_SIZE*REG_WIDTH-1:0] bram_rdata,
    output logic [CHANNELS*MATRIX_SIZE*REG_WIDTH-1:0] lane_data,
    output logic [MATRIX_SIZE-1:0]                    lane_valid,
    output logic                                      compute_start,
    output logic                                      busy,
    output logic                                      done
);

    // One lane word carries the same lane index of every channel side by side.
    localparam int LANE_W = CHANNELS * REG_WIDTH;
    // Drain counter counts 0..MATRIX_SIZE, i.e. MATRIX_SIZE+1 cycles.
    localparam int CNT_W  = (MATRIX_SIZE < 1) ? 1 : $clog2(MATRIX_SIZE + 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MATRIX_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] rows_reg;
    logic [CNT_W-1:0]      drain_cnt_reg;
    logic                  en_d1_reg;
    logic                  en_d2_reg;

    // Control FSM: all handshake and BRAM address outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rows_reg      <= '0;
            drain_cnt_reg <= '0;
            bram_en       <= 1'b0;
            bram_addr     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_reg <= FETCH;
                        rows_reg  <= rows_m1;
                        bram_en   <= 1'b1;
                        bram_addr <= '0;
                        busy      <= 1'b1;
                    end
                end
                FETCH: begin
                    // The address counter stops at the last row and then holds,
                    // so it can never wrap.
                    if (bram_addr == rows_reg) begin
                        bram_en       <= 1'b0;
                        drain_cnt_reg <= '0;
                        state_reg     <= DRAIN;
                    end else begin
                        bram_addr <= bram_addr + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    // Wait for the last row to clear the deepest skew stage.
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    bram_en   <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    // Track which cycles carry real BRAM data and flag the first lane-0 word.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_d1_reg     <= 1'b0;
            en_d2_reg     <= 1'b0;
            compute_start <= 1'b0;
        end else begin
            en_d1_reg     <= bram_en;
            en_d2_reg     <= en_d1_reg;
            compute_start <= en_d1_reg & ~en_d2_reg;
        end
    end

    // Per-lane capture register followed by gi skew stages.
    genvar gi, gc;
    generate
        for (gi = 0; gi < MATRIX_SIZE; gi++) begin : g_lane
            logic [LANE_W-1:0] lane_in;
            logic [LANE_W-1:0] data_stage  [0:gi];
            logic              valid_stage [0:gi];

            for (gc = 0; gc < CHANNELS; gc++) begin : g_gather
                assign lane_in[gc*REG_WIDTH +: REG_WIDTH] =
                    bram_rdata[(gc*MATRIX_SIZE+gi)*REG_WIDTH +: REG_WIDTH];
            end

            // Capture only on cycles that follow a BRAM read; zeros otherwise,
            // which flushes the diagonal edges to zero as it shifts through.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k <= gi; k++) begin
                        data_stage[k]  <= '0;
                        valid_stage[k] <= 1'b0;
                    end
                end else begin
                    data_stage[0]  <= en_d1_reg ? lane_in : '0;
                    valid_stage[0] <= en_d1_reg;
                    for (int k = 1; k <= gi; k++) begin
                        data_stage[k]  <= data_stage[k-1];
                        valid_stage[k] <= valid_stage[k-1];
                    end
                end
            end

            assign lane_valid[gi] = valid_stage[gi];

            for (gc = 0; gc < CHANNELS; gc++) begin : g_scatter
                assign lane_data[(gc*MATRIX_SIZE+gi)*REG_WIDTH +: REG_WIDTH] =
                    data_stage[gi][gc*REG_WIDTH +: REG_WIDTH];
            end
        end
    endgenerate

endmodule

// File: tb/tb_skew_feed_sequencer.sv
// Randomised self-checking bench for skew_feed_sequencer with a cycle-offset
// reference model derived from the start-acceptance cycle.
module tb_skew_feed_sequencer;

    localparam int M    = 4;
    localparam int W    = 16;
    localparam int A    = 2;
    localparam int C    = 2;
    localparam int DW   = C * M * W;
    localparam int ROWS = 1 << A;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [A-1:0]  rows_m1;
    logic          bram_en;
    logic [A-1:0]  bram_addr;
    logic [DW-1:0] bram_rdata;
    logic [DW-1:0] lane_data;
    logic [M-1:0]  lane_valid;
    logic          compute_start;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    skew_feed_sequencer #(
        .MATRIX_SIZE(M),
        .REG_WIDTH  (W),
        .ADDR_WIDTH (A),
        .CHANNELS   (C)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rows_m1      (rows_m1),
        .bram_en      (bram_en),
        .bram_addr    (bram_addr),
        .bram_rdata   (bram_rdata),
        .lane_data    (lane_data),
        .lane_valid   (lane_valid),
        .compute_start(compute_start),
        .busy         (busy),
        .done         (done)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [DW-1:0] mem  [ROWS];
    logic [DW-1:0] snap [ROWS];
    int            t_start  = -1000;
    int            r_lat    = 0;
    logic [A-1:0]  exp_addr = '0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, obs, exp_v);
        end
    endtask

    // Advance one clock; the BRAM model returns mem[addr] one cycle after a
    // read and random garbage on every other cycle.
    task automatic tick();
        logic         en_now;
        logic [A-1:0] a_now;
        en_now = bram_en;
        a_now  = bram_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (en_now) bram_rdata = mem[a_now];
        else        bram_rdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Drive one cycle of inputs, compare all outputs with the model, advance.
    task automatic cycle(input logic st, input logic [A-1:0] rm1, input logic rst);
        int            k;
        logic          e_en, e_busy, e_done, e_cs;
        logic [M-1:0]  e_val;
        logic [DW-1:0] e_data;
        start   = st;
        rows_m1 = rm1;
        reset   = rst;
        #1;
        k      = cyc - t_start;
        e_en   = (k >= 1) && (k <= 1 + r_lat);
        if (e_en) exp_addr = A'(k - 1);
        e_busy = (k >= 1) && (k <= 3 + r_lat + M);
        e_done = (k == 3 + r_lat + M);
        e_cs   = (k == 3);
        e_val  = '0;
        e_data = '0;
        for (int i = 0; i < M; i++) begin
            int r;
            r = k - 3 - i;
            if (r >= 0 && r <= r_lat) begin
                e_val[i] = 1'b1;
                for (int c = 0; c < C; c++)
                    e_data[(c*M+i)*W +: W] = snap[r][(c*M+i)*W +: W];
            end
        end
        check("bram_en",       DW'(bram_en),       DW'(e_en));
        check("bram_addr",     DW'(bram_addr),     DW'(exp_addr));
        check("busy",          DW'(busy),          DW'(e_busy));
        check("done",          DW'(done),          DW'(e_done));
        check("compute_start", DW'(compute_start), DW'(e_cs));
        check("lane_valid",    DW'(lane_valid),    DW'(e_val));
        check("lane_data",     lane_data,          e_data);
        if (rst) begin
            t_start  = -1000;
            exp_addr = '0;
            $display("reset cycle=%0d", cyc);
        end else if (st && !e_busy) begin
            t_start = cyc;
            r_lat   = int'(rm1);
            snap    = mem;
            $display("op accepted cycle=%0d rows_m1=%0d", cyc, rm1);
        end
        tick();
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < C; c++)
                for (int i = 0; i < M; i++)
                    mem[r][(c*M+i)*W +: W] = W'(16*r + 4*c + i);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        rows_m1    = '0;
        bram_rdata = '0;
        for (int r = 0; r < ROWS; r++) mem[r] = '0;
        snap = mem;
        tick();
        tick();
        // Reset state
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 2'd3, 1'b1);

        // 1 and 5: full-depth run with the indexed pattern
        fill_pattern();
        cycle(1'b1, 2'd3, 1'b0);
        repeat (12) cycle(1'b0, A'($urandom), 1'b0);

        // 2: single row
        for (int r = 0; r < ROWS; r++) mem[r] = '0;
        mem[0][63:0] = 64'h0004_0003_0002_0001;
        cycle(1'b1, 2'd0, 1'b0);
        repeat (9) cycle(1'b0, 2'd2, 1'b0);

        // 3: starts while busy (including the done cycle) are ignored
        fill_pattern();
        for (int k = 0; k < 25; k++)
            cycle((k == 0 || k == 4 || k == 10 || k == 11), 2'd3, 1'b0);

        // 4: reset mid-run, then a fresh run
        for (int k = 0; k <= 5; k++) cycle(k == 0, 2'd3, k == 5);
        repeat (3) cycle(1'b0, 2'd3, 1'b0);
        cycle(1'b1, 2'd3, 1'b0);
        repeat (12) cycle(1'b0, 2'd1, 1'b0);

        // 6: channel isolation
        for (int r = 0; r < ROWS; r++) mem[r] = {{(M*W){1'b1}}, {(M*W){1'b0}}};
        cycle(1'b1, 2'd3, 1'b0);
        repeat (12) cycle(1'b0, 2'd3, 1'b0);

        // Randomised operations with spurious starts and occasional resets
        repeat (25) begin
            for (int r = 0; r < ROWS; r++) mem[r] = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 3)) cycle(1'b0, A'($urandom), 1'b0);
            cycle(1'b1, A'($urandom), 1'b0);
            for (int k = 1; k < 20; k++) begin
                logic st, rs;
                st = (k <= 6) && ($urandom_range(0, 3) == 0);
                rs = (k <= 6) && ($urandom_range(0, 39) == 0);
                cycle(st, A'($urandom), rs);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
